// File: rtl/dst4_mac_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : dst4_mac_sched_if
//  Purpose  : Bundle of the sample-input stream, the MAC operand/result bus
//             and the coefficient output stream of the DST-4 MAC sequencer.
//             "master" is the sequencer side, "slave" is its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface dst4_mac_sched_if #(
    parameter int IN_W    = 12,
    parameter int COEFF_W = 8,
    parameter int ACC_W   = IN_W + COEFF_W + 2,
    parameter int Y_W     = 16
);
    // input vector stream
    logic                      in_valid;
    logic                      in_ready;
    logic signed [IN_W-1:0]    in_x [0:3];
    logic                      in_inv;

    // shared combinational MAC
    logic signed [IN_W-1:0]    mac_x [0:3];
    logic signed [COEFF_W-1:0] mac_c [0:3];
    logic signed [ACC_W-1:0]   mac_y;

    // output coefficient stream
    logic                      out_valid;
    logic                      out_ready;
    logic signed [Y_W-1:0]     out_data;
    logic [1:0]                out_idx;
    logic                      out_last;

    modport master (
        input  in_valid, in_x, in_inv, mac_y, out_ready,
        output in_ready, mac_x, mac_c, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        output in_valid, in_x, in_inv, mac_y, out_ready,
        input  in_ready, mac_x, mac_c, out_valid, out_data, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/dst4_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dst4_mac_sched
//  Purpose  : Sequencer for the shared 4-tap MAC of the 4-point DST-VII
//             stage. Captures one sample vector, steps through the four
//             coefficient rows (forward C or transposed C^T), rounds,
//             shifts and saturates each MAC result and streams the four
//             indexed coefficients out under valid/ready backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module dst4_mac_sched #(
    parameter int IN_W    = 12,
    parameter int COEFF_W = 8,
    parameter int ACC_W   = IN_W + COEFF_W + 2,
    parameter int Y_W     = 16,
    parameter int SHIFT   = 7
) (
    input  wire              clk,
    input  wire              rst_n,
    dst4_mac_sched_if.master bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // Saturation bounds expressed at the rounded-intermediate width.
    localparam logic signed [ACC_W:0] c_YMAX =
        $signed({{(ACC_W + 2 - Y_W){1'b0}}, {(Y_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] c_YMIN =
        $signed({{(ACC_W + 2 - Y_W){1'b1}}, {(Y_W - 1){1'b0}}});

    logic [0:0]               r_state;
    logic [0:0]               w_next_state;
    logic [1:0]               r_k;
    logic signed [IN_W-1:0]   r_x [0:3];
    logic                     r_inv;
    logic                     r_out_valid;
    logic signed [Y_W-1:0]    r_out_data;
    logic [1:0]               r_out_idx;
    logic                     r_out_last;

    logic                     w_accept;
    logic                     w_load;
    logic signed [ACC_W:0]    w_rnd;
    logic signed [Y_W-1:0]    w_sat;

    // DST-VII matrix C, addressed as C[r][c].
    function automatic logic signed [COEFF_W-1:0] coef(input logic [1:0] r,
                                                       input logic [1:0] c);
        int v;
        case ({r, c})
            4'h0: v = 29;   4'h1: v = 55;   4'h2: v = 74;   4'h3: v = 84;
            4'h4: v = 74;   4'h5: v = 74;   4'h6: v = 0;    4'h7: v = -74;
            4'h8: v = 84;   4'h9: v = -29;  4'hA: v = -74;  4'hB: v = 55;
            4'hC: v = 55;   4'hD: v = -84;  4'hE: v = 74;   4'hF: v = -29;
            default: v = 0;
        endcase
        return COEFF_W'(v);
    endfunction

    assign w_accept = (r_state == c_IDLE) && bus.in_valid;
    // A row is loaded whenever the output slot is empty or being drained.
    assign w_load   = (r_state == c_RUN) && (!r_out_valid || bus.out_ready);

    // Round-half-up then arithmetic shift, one extra bit for the carry.
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] c_HALF =
                $signed({{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1));
            logic signed [ACC_W:0] w_sum;
            assign w_sum = $signed({bus.mac_y[ACC_W-1], bus.mac_y}) + c_HALF;
            assign w_rnd = w_sum >>> SHIFT;
        end else begin : g_pass
            assign w_rnd = {bus.mac_y[ACC_W-1], bus.mac_y};
        end
    endgenerate

    assign w_sat = (w_rnd > c_YMAX) ? c_YMAX[Y_W-1:0] :
                   (w_rnd < c_YMIN) ? c_YMIN[Y_W-1:0] :
                                      w_rnd[Y_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: leave IDLE on accept, return after the row-3 load.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next_state = c_RUN;
            c_RUN:   if (w_load && (r_k == 2'd3)) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs decoded from state: ready in IDLE, MAC operands only in RUN.
    always_comb begin
        bus.in_ready = (r_state == c_IDLE);
        for (int j = 0; j < 4; j++) begin
            bus.mac_x[j] = '0;
            bus.mac_c[j] = '0;
            if (r_state == c_RUN) begin
                bus.mac_x[j] = r_x[j];
                bus.mac_c[j] = r_inv ? coef(2'(j), r_k) : coef(r_k, 2'(j));
            end
        end
    end

    // Vector capture and row counter; the vector is frozen until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) r_x[j] <= '0;
            r_inv <= 1'b0;
            r_k   <= 2'd0;
        end else if (w_accept) begin
            for (int j = 0; j < 4; j++) r_x[j] <= bus.in_x[j];
            r_inv <= bus.in_inv;
            r_k   <= 2'd0;
        end else if (w_load && (r_k != 2'd3)) begin
            r_k <= r_k + 2'd1;
        end
    end

    // Output slot: load a new row or drop valid once it has been taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= 2'd0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat;
            r_out_idx   <= r_k;
            r_out_last  <= (r_k == 2'd3);
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire
